// File: rtl/merged_pin_demux.sv
// merged_pin_demux: deframes a time-multiplexed shared pin into NUM_PINS
// parallel outputs, checking even parity and updating the bus atomically
// once per good frame.
module merged_pin_demux #(
    parameter int unsigned          NUM_PINS  = 4,
    parameter logic [NUM_PINS-1:0]  RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slot_en,
    input  logic                sync_in,
    input  logic                shared_in,
    output logic [NUM_PINS-1:0] pins_out,
    output logic                pins_valid,
    output logic                parity_err,
    output logic                frame_abort,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(NUM_PINS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PINS-1:0] shadow_q, shadow_d;
    logic                par_q, par_d;
    logic [NUM_PINS-1:0] pins_d;
    logic                valid_d;
    logic                err_d;
    logic                abort_d;

    // State, frame bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            par_q       <= 1'b0;
            pins_out    <= RESET_VAL;
            pins_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            par_q       <= par_d;
            pins_out    <= pins_d;
            pins_valid  <= valid_d;
            parity_err  <= err_d;
            frame_abort <= abort_d;
            busy        <= (state_d != IDLE);
        end
    end

    // Next-state logic: a sampled sync always starts a fresh frame; pulses
    // default low so they never stretch across idle slot_en cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        pins_d   = pins_out;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        abort_d  = 1'b0;

        if (slot_en) begin
            if (sync_in) begin
                // Slot 0 of a new frame, possibly restarting one in progress.
                abort_d     = (state_q != IDLE);
                shadow_d    = '0;
                shadow_d[0] = shared_in;
                par_d       = shared_in;
                cnt_d       = CNT_W'(1);
                state_d     = SHIFT;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // Slots outside a frame are ignored.
                    end
                    SHIFT: begin
                        for (int i = 1; i < NUM_PINS; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shadow_d[i] = shared_in;
                            end
                        end
                        par_d = par_q ^ shared_in;
                        if (cnt_q == CNT_W'(NUM_PINS - 1)) begin
                            cnt_d   = CNT_W'(NUM_PINS);
                            state_d = PARITY;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        if ((par_q ^ shared_in) == 1'b0) begin
                            pins_d  = shadow_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        state_d = IDLE;
                    end
                    default: begin
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_merged_pin_demux.sv
// Directed self-checking bench for merged_pin_demux (NUM_PINS=4, RESET_VAL=1010).
module tb_merged_pin_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       slot_en;
    logic       sync_in;
    logic       shared_in;
    logic [3:0] pins_out;
    logic       pins_valid;
    logic       parity_err;
    logic       frame_abort;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int valid_count = 0;

    merged_pin_demux #(
        .NUM_PINS  (4),
        .RESET_VAL (4'b1010)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .slot_en     (slot_en),
        .sync_in     (sync_in),
        .shared_in   (shared_in),
        .pins_out    (pins_out),
        .pins_valid  (pins_valid),
        .parity_err  (parity_err),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Counts pins_valid pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (pins_valid) valid_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return just after the rising edge.
    task automatic step(input logic en, input logic sy, input logic d);
        @(negedge clk);
        slot_en   = en;
        sync_in   = sy;
        shared_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; slot_en = 1'b0; sync_in = 1'b0; shared_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values.
        check("rst_pins",  32'(pins_out), 32'hA);
        check("rst_valid", 32'(pins_valid), 0);
        check("rst_err",   32'(parity_err), 0);
        check("rst_abort", 32'(frame_abort), 0);
        check("rst_busy",  32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;

        // Good frame 1,0,1,1 / parity 1.
        step(1, 1, 1);
        check("g_busy_rise", 32'(busy), 1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        check("g_no_partial", 32'(pins_out), 32'hA);
        check("g_no_valid",   32'(pins_valid), 0);
        step(1, 0, 1);
        check("g_pins",  32'(pins_out), 32'hD);
        check("g_valid", 32'(pins_valid), 1);
        check("g_busy_fall", 32'(busy), 0);
        step(0, 0, 0);
        check("g_valid_one", 32'(pins_valid), 0);

        // Same data with bad parity.
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        check("b_err",   32'(parity_err), 1);
        check("b_valid", 32'(pins_valid), 0);
        check("b_pins",  32'(pins_out), 32'hD);
        step(0, 0, 0);
        check("b_err_one", 32'(parity_err), 0);

        // Abort at slot 2, then good frame 0,1,1,0 / parity 0.
        valid_count = 0;
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        check("a_abort", 32'(frame_abort), 1);
        check("a_busy",  32'(busy), 1);
        check("a_pins",  32'(pins_out), 32'hD);
        step(1, 0, 1);
        check("a_abort_one", 32'(frame_abort), 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        check("a_pins_final", 32'(pins_out), 32'h6);
        check("a_valid", 32'(pins_valid), 1);
        check("a_err",   32'(parity_err), 0);
        step(0, 0, 0);
        check("a_valid_count", 32'(valid_count), 1);

        // slot_en toggling during good frame 1,1,0,0 / parity 0.
        step(1, 1, 1);
        step(0, 1, 0);
        check("t_hold_busy",  32'(busy), 1);
        check("t_no_abort",   32'(frame_abort), 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 1);
        step(1, 0, 0);
        step(0, 0, 1);
        check("t_no_early", 32'(pins_out), 32'h6);
        check("t_no_valid", 32'(pins_valid), 0);
        step(1, 0, 0);
        check("t_pins",  32'(pins_out), 32'h3);
        check("t_valid", 32'(pins_valid), 1);
        step(0, 0, 0);

        // Asynchronous reset after slot 2.
        step(1, 1, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        #3 rst = 1'b1;
        #1;
        check("r_pins", 32'(pins_out), 32'hA);
        check("r_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0, 1);
        check("r_ignored_busy",  32'(busy), 0);
        check("r_ignored_valid", 32'(pins_valid), 0);
        check("r_ignored_pins",  32'(pins_out), 32'hA);

        // Good frame 0,0,0,1 / parity 1, back-to-back with 1,1,1,1 / parity 0.
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        check("r_pins_after", 32'(pins_out), 32'h8);
        check("r_valid_after", 32'(pins_valid), 1);
        step(1, 1, 1);
        check("bb_busy",  32'(busy), 1);
        check("bb_valid", 32'(pins_valid), 0);
        check("bb_abort", 32'(frame_abort), 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        check("bb_pins",  32'(pins_out), 32'hF);
        check("bb_valid2", 32'(pins_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
